seg_display_driver: RTL and testbench
=====================================

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 The block SHALL have one parameter: BLANK_LEADING, default 1, meaning 1 = leading-zero digits dark, 0 = all four digits always lit.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all registers.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port digit_sel, input, 2 bits: digit-scan index from the refresh counter (0 = leftmost/thousands ... 3 = rightmost/ones).
REQ-005 The block SHALL have port value, input, 14 bits: unsigned binary number to display.
REQ-006 The block SHALL have port value_load, input, 1 bit: single-cycle request to capture value.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port overflow, output, 1 bit: high while the displayed value exceeds 9999.
REQ-009 The block SHALL have port an, output, 4 bits: active-low anodes, where an[3] = leftmost digit.
REQ-010 The block SHALL have port seg, output, 7 bits: active-low cathodes, ordered {g,f,e,d,c,b,a}.

Function
REQ-011 The block SHALL use a three-state FSM with states IDLE, CONV and COMMIT.
REQ-012 In IDLE, value_load=1 SHALL capture value into a shift register, clear the 16-bit BCD accumulator, and move to CONV.
REQ-013 CONV SHALL run exactly 14 cycles of double-dabble, one bit per cycle, MSB first: add 3 to every BCD nibble >= 5, then shift left by one.
REQ-014 After the 14th CONV cycle the FSM SHALL enter COMMIT for 1 cycle, then return to IDLE.
REQ-015 COMMIT SHALL write the BCD result into the 4-nibble display register and update overflow (1 if captured value > 9999, else 0).
REQ-016 The display register SHALL change only in COMMIT, so the display never shows a partial conversion.
REQ-017 busy SHALL be 1 in CONV and COMMIT, and 0 in IDLE.
REQ-018 Latency SHALL be: load sampled at edge N; display register and overflow valid after edge N+15; busy low after edge N+15.
REQ-019 value_load while busy=1 (including the COMMIT cycle) SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-020 Values 10000..16383 SHALL set overflow=1, and all four digits SHALL show dash (seg=7'b0111111, all anodes active) regardless of BLANK_LEADING.
REQ-021 an and seg SHALL be registered, reflecting the digit_sel value sampled at the same edge (one-cycle latency).
REQ-022 The anode mapping SHALL be: digit_sel 0 -> an=4'b0111, 1 -> 4'b1011, 2 -> 4'b1101, 3 -> 4'b1110.
REQ-023 The digit encodings on seg SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-024 With BLANK_LEADING=1, a digit SHALL be blanked (an=4'b1111, seg=7'b1111111) when it and all digits to its left are zero; the ones digit SHALL never be blanked.
REQ-025 Only the selected digit SHALL ever be driven low on an; at most one an bit SHALL be 0 per cycle.
REQ-026 digit_sel changes mid-conversion SHALL keep scanning the old display register contents without glitches.

Reset
REQ-027 While reset=1 the FSM SHALL be held in IDLE, busy=0, overflow=0, display register=0, an=4'b1111, seg=7'b1111111.
REQ-028 Reset asserted mid-CONV or during COMMIT SHALL abort the conversion, with the display register remaining 0.
REQ-029 On the first clk edge after reset deassertion the block SHALL scan normally; with BLANK_LEADING=1 it SHALL show "0" on the ones digit only.

Verification
REQ-030 Load value=1234, then cycle digit_sel 0..3 -> busy high for exactly 15 cycles; then an/seg = 0111/1111001, 1011/0100100, 1101/0110000, 1110/0011001.
REQ-031 Load value=7 with BLANK_LEADING=1 -> digit_sel 0..2 give an=1111, and digit_sel=3 gives an=1110, seg=1111000; with BLANK_LEADING=0, digits 0..2 show seg=1000000.
REQ-032 Load value=12000 -> overflow=1 and all four digits show seg=0111111; then load 9999 -> overflow=0 and every digit shows seg=0010000.
REQ-033 Load 4321, then pulse value_load with 5555 at cycles +3 and +15 (COMMIT) -> display 4321, and the second and third loads are ignored.
REQ-034 Load 8888, assert reset at conversion cycle 7 -> busy=0, an=1111 during reset; afterwards only the ones digit shows "0".
REQ-035 Load 100 -> the thousands digit is blanked and digit_sel 1..3 show 1,0,0; the interior zeros are not blanked.

Source files
------------

// File: rtl/seg_display_driver.sv
// Four-digit seven-segment driver: binary value -> BCD via serial double-dabble,
// committed atomically to a display register and scanned out on registered an/seg.
module seg_display_driver #(
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  digit_sel,
  input  logic [13:0] value,
  input  logic        value_load,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_cap_q, ovf_cap_d;
  logic [15:0] disp_q, disp_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        load_s, step_s, commit_s;
  logic [3:0]  nib_s;
  logic        lead_zero_s;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [15:0] dabble_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] adj;
    adj = {add3(b[15:12]), add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
    return (adj << 1) | {15'd0, in_bit};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] anode_map(input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0111;
      2'd1:    return 4'b1011;
      2'd2:    return 4'b1101;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: load only accepted in IDLE, 14 conversion cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (value_load) state_d = CONV; else state_d = IDLE;
      CONV:    if (cnt_q == 4'd13) state_d = COMMIT; else state_d = CONV;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and the next busy value
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    commit_s = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE:    load_s   = value_load;
      CONV:    step_s   = 1'b1;
      COMMIT:  commit_s = 1'b1;
      default: load_s   = 1'b0;
    endcase
  end

  // Conversion datapath; the display register only moves on commit
  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_cap_d  = ovf_cap_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    if (load_s) begin
      shift_d   = value;
      bcd_d     = 16'd0;
      cnt_d     = 4'd0;
      ovf_cap_d = (value > 14'd9999);
    end else if (step_s) begin
      bcd_d   = dabble_step(bcd_q, shift_q[13]);
      shift_d = {shift_q[12:0], 1'b0};
      cnt_d   = cnt_q + 4'd1;
    end else if (commit_s) begin
      disp_d     = bcd_q;
      overflow_d = ovf_cap_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Digit selection and leading-zero detection for the scan output
  always_comb begin
    nib_s       = 4'd0;
    lead_zero_s = 1'b0;
    case (digit_sel)
      2'd0:    begin nib_s = disp_q[15:12]; lead_zero_s = (disp_q[15:12] == 4'd0); end
      2'd1:    begin nib_s = disp_q[11:8];  lead_zero_s = (disp_q[15:8]  == 8'd0); end
      2'd2:    begin nib_s = disp_q[7:4];   lead_zero_s = (disp_q[15:4]  == 12'd0); end
      2'd3:    begin nib_s = disp_q[3:0];   lead_zero_s = 1'b0; end
      default: begin nib_s = 4'd0;          lead_zero_s = 1'b0; end
    endcase
  end

  // Next anode/cathode pattern: dashes on overflow, optional leading blanking
  always_comb begin
    an_d  = anode_map(digit_sel);
    seg_d = seg_enc(nib_s);
    if (overflow_q) begin
      seg_d = 7'b0111111;
    end else if ((BLANK_LEADING != 0) && lead_zero_s) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_enc(nib_s);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= 14'd0;
      bcd_q      <= 16'd0;
      cnt_q      <= 4'd0;
      ovf_cap_q  <= 1'b0;
      disp_q     <= 16'd0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_cap_q  <= ovf_cap_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: one instance with leading blanking, one without,
// sharing all inputs; table-driven scan checks plus load-ignore and reset-abort sequences.
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  digit_sel;
  logic [13:0] value;
  logic        value_load;
  logic        busy1, overflow1, busy0, overflow0;
  logic [3:0]  an1, an0;
  logic [6:0]  seg1, seg0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [13:0] value;
    logic [1:0]  sel;
    logic [3:0]  an1;
    logic [6:0]  seg1;
    logic [3:0]  an0;
    logic [6:0]  seg0;
    logic        ovf;
  } vec_t;

  vec_t vec[23];

  seg_display_driver #(.BLANK_LEADING(1)) dut1 (
    .clk(clk), .reset(reset), .digit_sel(digit_sel), .value(value), .value_load(value_load),
    .busy(busy1), .overflow(overflow1), .an(an1), .seg(seg1)
  );

  seg_display_driver #(.BLANK_LEADING(0)) dut0 (
    .clk(clk), .reset(reset), .digit_sel(digit_sel), .value(value), .value_load(value_load),
    .busy(busy0), .overflow(overflow0), .an(an0), .seg(seg0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [13:0] v);
    value      = v;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
  endtask

  task automatic wait_idle(input int exp_cycles);
    int n;
    n = 0;
    while (busy1 && n < 40) begin
      tick();
      n++;
    end
    chk("busy_cycles", 16'(n), 16'(exp_cycles));
  endtask

  task automatic scan(input string name, input logic [1:0] s,
                      input logic [3:0] e_an1, input logic [6:0] e_seg1,
                      input logic [3:0] e_an0, input logic [6:0] e_seg0);
    digit_sel = s;
    tick();
    chk({name, "_an1"},  {12'd0, an1},  {12'd0, e_an1});
    chk({name, "_seg1"}, {9'd0, seg1},  {9'd0, e_seg1});
    chk({name, "_an0"},  {12'd0, an0},  {12'd0, e_an0});
    chk({name, "_seg0"}, {9'd0, seg0},  {9'd0, e_seg0});
  endtask

  initial begin
    vec[0]  = '{14'd1234,  2'd0, 4'b0111, 7'b1111001, 4'b0111, 7'b1111001, 1'b0};
    vec[1]  = '{14'd1234,  2'd1, 4'b1011, 7'b0100100, 4'b1011, 7'b0100100, 1'b0};
    vec[2]  = '{14'd1234,  2'd2, 4'b1101, 7'b0110000, 4'b1101, 7'b0110000, 1'b0};
    vec[3]  = '{14'd1234,  2'd3, 4'b1110, 7'b0011001, 4'b1110, 7'b0011001, 1'b0};
    vec[4]  = '{14'd7,     2'd0, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000, 1'b0};
    vec[5]  = '{14'd7,     2'd1, 4'b1111, 7'b1111111, 4'b1011, 7'b1000000, 1'b0};
    vec[6]  = '{14'd7,     2'd2, 4'b1111, 7'b1111111, 4'b1101, 7'b1000000, 1'b0};
    vec[7]  = '{14'd7,     2'd3, 4'b1110, 7'b1111000, 4'b1110, 7'b1111000, 1'b0};
    vec[8]  = '{14'd12000, 2'd0, 4'b0111, 7'b0111111, 4'b0111, 7'b0111111, 1'b1};
    vec[9]  = '{14'd12000, 2'd3, 4'b1110, 7'b0111111, 4'b1110, 7'b0111111, 1'b1};
    vec[10] = '{14'd9999,  2'd0, 4'b0111, 7'b0010000, 4'b0111, 7'b0010000, 1'b0};
    vec[11] = '{14'd9999,  2'd3, 4'b1110, 7'b0010000, 4'b1110, 7'b0010000, 1'b0};
    vec[12] = '{14'd10000, 2'd1, 4'b1011, 7'b0111111, 4'b1011, 7'b0111111, 1'b1};
    vec[13] = '{14'd100,   2'd0, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000, 1'b0};
    vec[14] = '{14'd100,   2'd1, 4'b1011, 7'b1111001, 4'b1011, 7'b1111001, 1'b0};
    vec[15] = '{14'd100,   2'd2, 4'b1101, 7'b1000000, 4'b1101, 7'b1000000, 1'b0};
    vec[16] = '{14'd100,   2'd3, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000, 1'b0};
    vec[17] = '{14'd1050,  2'd1, 4'b1011, 7'b1000000, 4'b1011, 7'b1000000, 1'b0};
    vec[18] = '{14'd1050,  2'd2, 4'b1101, 7'b0010010, 4'b1101, 7'b0010010, 1'b0};
    vec[19] = '{14'd16383, 2'd2, 4'b1101, 7'b0111111, 4'b1101, 7'b0111111, 1'b1};
    vec[20] = '{14'd60,    2'd1, 4'b1111, 7'b1111111, 4'b1011, 7'b1000000, 1'b0};
    vec[21] = '{14'd60,    2'd2, 4'b1101, 7'b0000010, 4'b1101, 7'b0000010, 1'b0};
    vec[22] = '{14'd60,    2'd3, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000, 1'b0};

    reset      = 1'b1;
    digit_sel  = 2'd0;
    value      = 14'd0;
    value_load = 1'b0;

    // Reset state, with digit_sel moving under reset
    tick();
    digit_sel = 2'd3;
    tick();
    chk("rst_busy", {15'd0, busy1}, 16'd0);
    chk("rst_ovf",  {15'd0, overflow1}, 16'd0);
    chk("rst_an",   {12'd0, an1}, 16'h000f);
    chk("rst_seg",  {9'd0, seg1}, 16'h007f);
    chk("rst_an0",  {12'd0, an0}, 16'h000f);

    reset = 1'b0;
    scan("post_rst_d3", 2'd3, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000);
    scan("post_rst_d0", 2'd0, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000);

    for (int i = 0; i < 23; i++) begin
      if (i == 0 || vec[i].value != vec[i-1].value) begin
        load(vec[i].value);
        wait_idle(15);
      end
      scan($sformatf("vec%0d", i), vec[i].sel, vec[i].an1, vec[i].seg1, vec[i].an0, vec[i].seg0);
      chk($sformatf("vec%0d_ovf", i), {15'd0, overflow1}, {15'd0, vec[i].ovf});
    end

    // 4321 with ignored loads at +3 and at the commit cycle; old display held meanwhile
    digit_sel = 2'd3;
    load(14'd4321);
    tick();
    tick();
    value      = 14'd5555;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    chk("midconv_busy", {15'd0, busy1}, 16'd1);
    chk("midconv_seg",  {9'd0, seg1}, 16'(7'b1000000));
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
    chk("commit_done_busy", {15'd0, busy1}, 16'd0);
    tick();
    chk("commit_load_ignored", {15'd0, busy1}, 16'd0);
    scan("ign_d0", 2'd0, 4'b0111, 7'b0011001, 4'b0111, 7'b0011001);
    scan("ign_d1", 2'd1, 4'b1011, 7'b0110000, 4'b1011, 7'b0110000);
    scan("ign_d2", 2'd2, 4'b1101, 7'b0100100, 4'b1101, 7'b0100100);
    scan("ign_d3", 2'd3, 4'b1110, 7'b1111001, 4'b1110, 7'b1111001);

    // Reset abort in the middle of converting 8888
    load(14'd8888);
    for (int k = 0; k < 7; k++) tick();
    reset = 1'b1;
    #2;
    chk("abort_busy", {15'd0, busy1}, 16'd0);
    chk("abort_an",   {12'd0, an1}, 16'h000f);
    chk("abort_seg",  {9'd0, seg1}, 16'h007f);
    tick();
    tick();
    chk("abort_an_hold", {12'd0, an1}, 16'h000f);
    reset = 1'b0;
    scan("abort_d3", 2'd3, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000);
    scan("abort_d0", 2'd0, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000);
    scan("abort_d2", 2'd2, 4'b1111, 7'b1111111, 4'b1101, 7'b1000000);
    chk("abort_busy_after", {15'd0, busy1}, 16'd0);
    chk("abort_ovf_after",  {15'd0, overflow1}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
